fir_coeff_loader: RTL and testbench

//  Writer side of the FIR coefficient interface. Receives coefficients one per beat on a

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_coeff_bank.sv | 53 +++++
 rtl/fir_coeff_loader.sv | 156 +++++++++++++++
 tb/tb_fir_coeff_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader: default geometry, coefficient type,
// loader state encoding and the tap bit-offset helper.
package fir_pkg;

    localparam int unsigned COEFF_WIDTH_DEFAULT = 16;
    localparam int unsigned NUM_TAPS_DEFAULT    = 32;

    typedef logic signed [COEFF_WIDTH_DEFAULT-1:0] coeff_t;

    // Loader states; StCheck is only reachable when the checksum beat is enabled.
    typedef logic [1:0] state_t;
    localparam state_t StIdle   = 2'd0;
    localparam state_t StLoad   = 2'd1;
    localparam state_t StCheck  = 2'd2;
    localparam state_t StCommit = 2'd3;

    // Bit offset of tap i inside a flattened coefficient bus.
    function automatic int unsigned tap_slice(input int unsigned i,
                                              input int unsigned cw = COEFF_WIDTH_DEFAULT);
        return i * cw;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow and active coefficient register arrays. The shadow bank is written one tap at a
// time; a commit strobe copies the whole shadow bank into the active bank in one cycle.
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int unsigned COEFF_WIDTH = COEFF_WIDTH_DEFAULT,
    parameter int unsigned NUM_TAPS    = NUM_TAPS_DEFAULT,
    parameter int unsigned IDX_WIDTH   = $clog2(NUM_TAPS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            we,
    input  logic [IDX_WIDTH-1:0]            idx,
    input  logic [COEFF_WIDTH-1:0]          data,
    input  logic                            commit,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff_flat
);

    logic [COEFF_WIDTH-1:0] shadow_q [NUM_TAPS];
    logic [COEFF_WIDTH-1:0] active_q [NUM_TAPS];

    // Shadow bank: cleared at reset and at frame start, written per accepted beat.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                shadow_q[i] <= '0;
            end
        end else if (we) begin
            shadow_q[idx] <= data;
        end
    end

    // Active bank: only reset and commit may change what the filter sees.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                active_q[i] <= '0;
            end
        end else if (commit) begin
            active_q <= shadow_q;
        end
    end

    // Flatten the active bank, tap 0 in the least significant slice.
    always_comb begin
        coeff_flat = '0;
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            coeff_flat[tap_slice(i, COEFF_WIDTH) +: COEFF_WIDTH] = active_q[i];
        end
    end

endmodule

// File: rtl/fir_coeff_loader.sv
// Writer side of the FIR coefficient interface: accepts one coefficient per valid/ready
// beat into a shadow bank and commits it atomically on a well-formed frame.
// Optional feature macro: FIR_COEFF_LOADER_CHECKSUM_EN appends a checksum beat (sum of all
// taps mod 2^COEFF_WIDTH) that must match before the frame is committed.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int unsigned COEFF_WIDTH = COEFF_WIDTH_DEFAULT,
    parameter int unsigned NUM_TAPS    = NUM_TAPS_DEFAULT,
    parameter int unsigned IDX_WIDTH   = $clog2(NUM_TAPS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_start,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [COEFF_WIDTH-1:0]          s_data,
    input  logic                            s_last,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff_flat
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_TAPS - 1);

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   hs;
    logic                   bank_we, bank_clear, bank_commit;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
    logic [COEFF_WIDTH-1:0] csum_q, csum_d;
`endif

    assign s_ready = (state_q == StLoad) || (state_q == StCheck);
    assign busy    = (state_q != StIdle);
    assign hs      = s_valid && s_ready;
    assign done    = done_q;
    assign err     = err_q;

    // Next-state, index and bank-control decode.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        bank_we     = 1'b0;
        bank_clear  = 1'b0;
        bank_commit = 1'b0;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d    = StLoad;
                    idx_d      = '0;
                    bank_clear = 1'b1;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            StLoad: begin
                if (hs) begin
                    bank_we = 1'b1;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
                    csum_d  = csum_q + s_data;
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
                        // s_last belongs on the checksum beat, not on the final tap.
                        if (s_last) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StCheck;
                        end
`else
                        if (s_last) begin
                            state_d = StCommit;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
`endif
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
            StCheck: begin
                if (hs) begin
                    if (s_last && (s_data == csum_q)) begin
                        state_d = StCommit;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
`endif
            StCommit: begin
                bank_commit = 1'b1;
                done_d      = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, index and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    fir_coeff_bank #(
        .COEFF_WIDTH (COEFF_WIDTH),
        .NUM_TAPS    (NUM_TAPS),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .clear      (bank_clear),
        .we         (bank_we),
        .idx        (idx_q),
        .data       (s_data),
        .commit     (bank_commit),
        .coeff_flat (coeff_flat)
    );

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: directed frames with random coefficient values,
// random valid gaps and a reference model of the active bank.
module tb_fir_coeff_loader;
    import fir_pkg::*;

    localparam int unsigned CW = 16;
    localparam int unsigned NT = 32;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             load_start;
    logic             s_valid;
    logic             s_ready;
    logic [CW-1:0]    s_data;
    logic             s_last;
    logic             busy;
    logic             done;
    logic             err;
    logic [NT*CW-1:0] coeff_flat;

    int vectors     = 0;
    int miscompares = 0;

    logic [CW-1:0] frame [NT];
    logic [CW-1:0] model [NT];

    always #5 clk = ~clk;

    fir_coeff_loader #(
        .COEFF_WIDTH (CW),
        .NUM_TAPS    (NT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .coeff_flat (coeff_flat)
    );

    function automatic logic [NT*CW-1:0] pack_model();
        logic [NT*CW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(NT); i++) r[i*CW +: CW] = model[i];
        return r;
    endfunction

    function automatic logic [CW-1:0] frame_sum();
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < int'(NT); i++) s = s + frame[i];
        return s;
    endfunction

    task automatic chk(input string tag, input logic [NT*CW-1:0] obs, input logic [NT*CW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until a handshake edge; optionally pulse load_start
    // during the first cycle of the beat.
    task automatic send_beat(input logic [CW-1:0] data, input bit last, input bit ls_pulse);
        bit taken;
        bit rdy;
        bit ls;
        taken   = 1'b0;
        ls      = ls_pulse;
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        for (int t = 0; t < 64 && !taken; t++) begin
            rdy = s_ready;
            if (ls) load_start = 1'b1;
            step();
            load_start = 1'b0;
            ls         = 1'b0;
            taken      = rdy;
        end
        chk("handshake", 512'(taken), 512'(1));
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_frame(input int early_at, input bit final_last,
                             input logic [CW-1:0] csum_val, input bit gaps,
                             input bit mid_ls, input string tag);
        bit ok;
        bit l;
        bit stopped;
        ok      = (early_at < 0) && final_last && (!CSUM_EN || (csum_val == frame_sum()));
        stopped = 1'b0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk({tag, "_busy_start"}, 512'(busy), 512'(1));
        for (int i = 0; i < int'(NT) && !stopped; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) step();
            end
            if (i == early_at) l = 1'b1;
            else if (!CSUM_EN && i == int'(NT) - 1) l = final_last;
            else l = 1'b0;
            send_beat(frame[i], l, mid_ls && (i == 5));
            if (l && (CSUM_EN || i < int'(NT) - 1)) stopped = 1'b1;
        end
        if (CSUM_EN && !stopped) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            send_beat(csum_val, final_last, 1'b0);
        end
        if (ok) begin
            chk({tag, "_commit_err"}, 512'(err), 512'(0));
            chk({tag, "_commit_done"}, 512'(done), 512'(0));
            chk({tag, "_commit_ready"}, 512'(s_ready), 512'(0));
            chk({tag, "_commit_bank_old"}, coeff_flat, pack_model());
            step();
            for (int i = 0; i < int'(NT); i++) model[i] = frame[i];
            chk({tag, "_done"}, 512'(done), 512'(1));
            chk({tag, "_bank"}, coeff_flat, pack_model());
            chk({tag, "_busy_end"}, 512'(busy), 512'(0));
            step();
            chk({tag, "_done_pulse"}, 512'(done), 512'(0));
        end else begin
            chk({tag, "_err"}, 512'(err), 512'(1));
            chk({tag, "_no_done"}, 512'(done), 512'(0));
            chk({tag, "_idle"}, 512'(busy), 512'(0));
            step();
            chk({tag, "_err_pulse"}, 512'(err), 512'(0));
            chk({tag, "_bank_kept"}, coeff_flat, pack_model());
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < int'(NT); i++) frame[i] = CW'($urandom);
    endtask

    task automatic fill_count();
        for (int i = 0; i < int'(NT); i++) frame[i] = CW'(i + 1);
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        for (int i = 0; i < int'(NT); i++) model[i] = '0;

        step();
        step();
        rst = 1'b0;
        chk("rst_bank", coeff_flat, '0);
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_ready", 512'(s_ready), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_err", 512'(err), 512'(0));

        // Clean back-to-back load of 1..32.
        fill_count();
        run_frame(-1, 1'b1, frame_sum(), 1'b0, 1'b0, "clean");

        // Reset mid-frame clears everything and raises no pulse.
        fill_random();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(frame[i], 1'b0, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < int'(NT); i++) model[i] = '0;
        chk("midrst_bank", coeff_flat, '0);
        chk("midrst_busy", 512'(busy), 512'(0));
        chk("midrst_ready", 512'(s_ready), 512'(0));
        chk("midrst_done", 512'(done), 512'(0));
        chk("midrst_err", 512'(err), 512'(0));
        step();
        chk("midrst_done_after", 512'(done), 512'(0));
        chk("midrst_err_after", 512'(err), 512'(0));

        // Beats offered while idle are refused.
        s_valid = 1'b1;
        s_data  = 16'hdead;
        s_last  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("idle_ready", 512'(s_ready), 512'(0));
            chk("idle_busy", 512'(busy), 512'(0));
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("idle_no_err", 512'(err), 512'(0));

        // Same count frame with random gaps gives the clean result.
        fill_count();
        run_frame(-1, 1'b1, frame_sum(), 1'b1, 1'b0, "gaps");

        // s_last on beat 10.
        fill_random();
        run_frame(9, 1'b1, frame_sum(), 1'b0, 1'b0, "early_last");

        // Final beat missing s_last, then a fresh frame with an ignored mid-frame load_start.
        fill_random();
        run_frame(-1, 1'b0, frame_sum(), 1'b0, 1'b0, "missing_last");
        fill_random();
        run_frame(-1, 1'b1, frame_sum(), 1'b1, 1'b1, "reload");

`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
        for (int i = 0; i < int'(NT); i++) frame[i] = 16'h0800;
        run_frame(-1, 1'b1, 16'h0000, 1'b0, 1'b0, "csum_good");
        fill_random();
        for (int i = 0; i < int'(NT); i++) frame[i] = 16'h0800;
        run_frame(-1, 1'b1, 16'h0001, 1'b0, 1'b0, "csum_bad");
        fill_random();
        run_frame(int'(NT) - 1, 1'b1, frame_sum(), 1'b0, 1'b0, "csum_last_on_tap");
`endif

        // Random frames; every third carries an off-by-one checksum (only fatal with checksum).
        for (int k = 0; k < 4; k++) begin
            fill_random();
            run_frame(-1, 1'b1, frame_sum() + CW'(k == 2), 1'b1, 1'b0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so a stuck design cannot hang the run.
    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, expected completion before 400000");
        $fatal(1, "timeout");
    end

endmodule
